// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the commit trace buffer.
//   trace_state_e : capture FSM state (IDLE / RUN / FROZEN)
//   trace_entry_t : one captured commit {pc, inst, wvld, waddr, wdata[, cycle]}
//   TRACE_*_W     : field widths used by trace_entry_t
// Optional feature macro: TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp field.
package trace_pkg;

    localparam int TRACE_PC_W    = 32;
    localparam int TRACE_INST_W  = 32;
    localparam int TRACE_DATA_W  = 32;
    localparam int TRACE_RA_W    = 5;
    localparam int TRACE_CYCLE_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_PC_W-1:0]    pc;
        logic [TRACE_INST_W-1:0]  inst;
        logic                     wvld;
        logic [TRACE_RA_W-1:0]    waddr;
        logic [TRACE_DATA_W-1:0]  wdata;
`ifdef TRACE_TIMESTAMP_EN
        logic [TRACE_CYCLE_W-1:0] cycle;
`endif
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular buffer of trace entries with optional overwrite-oldest.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   push, push_data : store an entry this cycle
//   pop             : consume the head (ignored when empty)
//   head, head_vld  : oldest entry (all zero when empty)
//   count           : entries held, 0..DEPTH
//   ovf             : pulse, a push found the buffer full with no pop
// Parameters: DEPTH (power of 2, >=2), OVERWRITE (0 drop new, 1 drop head).
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH     = 16,
    parameter bit  OVERWRITE = 1'b0,
    parameter type entry_t   = trace_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     head_vld,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             wr_ok;
    logic             drop_head;
    logic             rd_adv;

    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && (count != '0);
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign wr_ok     = push && (!full || do_pop || OVERWRITE);
    assign drop_head = push && full && !do_pop && OVERWRITE;
    assign rd_adv    = do_pop || drop_head;
    assign ovf       = push && full && !do_pop;

    assign head_vld  = (count != '0);
    assign head      = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNT_W'(wr_ok) - CNT_W'(rd_adv);
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures CPU commits (pc change) into a trace buffer.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   pc, inst                   : CPU pc and instruction register
//   rf_we, rf_waddr, rf_wdata  : regfile write port (waddr 0 is not a write)
//   trace_en                   : 1 arm/run, 0 idle
//   trig_en, trig_pc           : freeze capture after the entry at trig_pc
//   rd_valid, rd_ready, rd_*   : drain port for the head entry
//   rd_wvld                    : head entry carries a register write
//   count                      : entries held
//   overflow                   : sticky, an entry was dropped or overwritten
//   frozen                     : trigger hit, capture halted
//   rd_cycle                   : capture cycle stamp (TRACE_TIMESTAMP_EN only)
//   dbg_state                  : current FSM state
// Optional feature macro: TRACE_TIMESTAMP_EN.
//
// Drain handshake: rd_valid/rd_* present the oldest entry and hold it stable
// until consumed; an entry transfers at a rising edge where rd_valid &&
// rd_ready; rd_valid never depends on rd_ready; a new capture is never
// bypassed to the port, it appears the cycle after its capture edge.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int PC_W      = TRACE_PC_W,
    parameter int INST_W    = TRACE_INST_W,
    parameter int DATA_W    = TRACE_DATA_W,
    parameter int RA_W      = TRACE_RA_W,
    parameter int DEPTH     = 16,
    parameter int FULL_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PC_W-1:0]          pc,
    input  logic [INST_W-1:0]        inst,
    input  logic                     rf_we,
    input  logic [RA_W-1:0]          rf_waddr,
    input  logic [DATA_W-1:0]        rf_wdata,
    input  logic                     trace_en,
    input  logic                     trig_en,
    input  logic [PC_W-1:0]          trig_pc,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PC_W-1:0]          rd_pc,
    output logic [INST_W-1:0]        rd_inst,
    output logic [RA_W-1:0]          rd_waddr,
    output logic [DATA_W-1:0]        rd_wdata,
    output logic                     rd_wvld,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frozen,
`ifdef TRACE_TIMESTAMP_EN
    output logic [31:0]              rd_cycle,
`endif
    output trace_state_e             dbg_state
);

    trace_state_e      state;
    trace_state_e      state_n;
    logic [PC_W-1:0]   pc_prev;
    logic              lat_vld;
    logic [RA_W-1:0]   lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              wr_hit;
    logic              capture;
    logic              trig_hit;
    logic              fifo_ovf;
    trace_entry_t      new_entry;
    trace_entry_t      head;

    assign wr_hit   = rf_we && (rf_waddr != '0);
    assign capture  = (state == RUN) && (pc != pc_prev);
    assign trig_hit = capture && trig_en && (pc == trig_pc);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trace_en) state_n = RUN;
            RUN: begin
                if (!trace_en)     state_n = IDLE;
                else if (trig_hit) state_n = FROZEN;
            end
            FROZEN:  if (!trace_en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pc_prev <= '0;
        end else begin
            state   <= state_n;
            pc_prev <= pc;
        end
    end

    // Last qualifying regfile write since the previous capture. A write in
    // the capture cycle goes straight into the entry, so capture wins here.
    always_ff @(posedge clk) begin
        if (!reset || capture) begin
            lat_vld  <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else if (wr_hit) begin
            lat_vld  <= 1'b1;
            lat_addr <= rf_waddr;
            lat_data <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (state == IDLE && trace_en) begin
            overflow <= 1'b0;
        end else if (fifo_ovf) begin
            overflow <= 1'b1;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        new_entry      = '0;
        new_entry.pc   = pc;
        new_entry.inst = inst;
        if (wr_hit) begin
            new_entry.wvld  = 1'b1;
            new_entry.waddr = rf_waddr;
            new_entry.wdata = rf_wdata;
        end else begin
            new_entry.wvld  = lat_vld;
            new_entry.waddr = lat_addr;
            new_entry.wdata = lat_data;
        end
`ifdef TRACE_TIMESTAMP_EN
        new_entry.cycle = cycle_cnt;
`endif
    end

    trace_fifo #(
        .DEPTH     (DEPTH),
        .OVERWRITE (FULL_MODE != 0),
        .entry_t   (trace_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (new_entry),
        .pop       (rd_ready),
        .head      (head),
        .head_vld  (rd_valid),
        .count     (count),
        .ovf       (fifo_ovf)
    );

    assign rd_pc     = head.pc;
    assign rd_inst   = head.inst;
    assign rd_wvld   = head.wvld;
    assign rd_waddr  = head.waddr;
    assign rd_wdata  = head.wdata;
`ifdef TRACE_TIMESTAMP_EN
    assign rd_cycle  = head.cycle;
`endif
    assign frozen    = (state == FROZEN);
    assign dbg_state = state;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: two DEPTH=4 instances share all
// inputs, one dropping new entries when full (u0) and one overwriting the
// oldest (u1).
module tb_commit_trace_buffer;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        trace_en;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        rd_ready;

    logic         rd_valid_0, rd_valid_1;
    logic [31:0]  rd_pc_0, rd_pc_1, rd_inst_0, rd_inst_1;
    logic [4:0]   rd_waddr_0, rd_waddr_1;
    logic [31:0]  rd_wdata_0, rd_wdata_1;
    logic         rd_wvld_0, rd_wvld_1;
    logic [2:0]   count_0, count_1;
    logic         overflow_0, overflow_1;
    logic         frozen_0, frozen_1;
    trace_state_e dbg_state_0, dbg_state_1;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]  rd_cycle_0, rd_cycle_1;
    logic [31:0]  c0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(4), .FULL_MODE(0)) u0 (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .trace_en(trace_en),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_valid(rd_valid_0),
        .rd_ready(rd_ready), .rd_pc(rd_pc_0), .rd_inst(rd_inst_0),
        .rd_waddr(rd_waddr_0), .rd_wdata(rd_wdata_0), .rd_wvld(rd_wvld_0),
        .count(count_0), .overflow(overflow_0), .frozen(frozen_0),
`ifdef TRACE_TIMESTAMP_EN
        .rd_cycle(rd_cycle_0),
`endif
        .dbg_state(dbg_state_0)
    );

    commit_trace_buffer #(.DEPTH(4), .FULL_MODE(1)) u1 (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .trace_en(trace_en),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_valid(rd_valid_1),
        .rd_ready(rd_ready), .rd_pc(rd_pc_1), .rd_inst(rd_inst_1),
        .rd_waddr(rd_waddr_1), .rd_wdata(rd_wdata_1), .rd_wvld(rd_wvld_1),
        .count(count_1), .overflow(overflow_1), .frozen(frozen_1),
`ifdef TRACE_TIMESTAMP_EN
        .rd_cycle(rd_cycle_1),
`endif
        .dbg_state(dbg_state_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; pc = '0; inst = '0; rf_we = 1'b0; rf_waddr = '0;
        rf_wdata = '0; trace_en = 1'b0; trig_en = 1'b0; trig_pc = '0;
        rd_ready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_valid", rd_valid_0, 0);
        check("rst_count", count_0, 0);
        check("rst_ovf", overflow_0, 0);
        check("rst_frozen", frozen_0, 0);
        check("rst_pc", rd_pc_0, 0);
        check("rst_state", dbg_state_0, IDLE);

        // 1: basic commits
        reset = 1'b1; trace_en = 1'b1;
        tick();
        check("t1_state_run", dbg_state_0, RUN);
        pc = 32'h4; inst = 32'h2001_0001;
        tick();
        check("t1_first_visible", rd_valid_0, 1);
        pc = 32'h8; inst = 32'h2002_0002;
        tick();
        check("t1_count", count_0, 2);
        check("t1_head_pc", rd_pc_0, 32'h4);
        check("t1_head_inst", rd_inst_0, 32'h2001_0001);
        check("t1_head_wvld", rd_wvld_0, 0);
        rd_ready = 1'b1;
        tick();
        check("t1_pc2", rd_pc_0, 32'h8);
        check("t1_inst2", rd_inst_0, 32'h2002_0002);
        tick();
        rd_ready = 1'b0;
        check("t1_empty", rd_valid_0, 0);
        check("t1_empty_pc", rd_pc_0, 0);

        // 2: write latch
        rf_we = 1'b1; rf_waddr = 5'd1; rf_wdata = 32'h5;
        tick();
        rf_waddr = 5'd2; rf_wdata = 32'h7;
        tick();
        rf_we = 1'b0; pc = 32'hC;
        tick();
        rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'h9;
        tick();
        rf_we = 1'b0; pc = 32'h10;
        tick();
        pc = 32'h14; rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h33;
        tick();
        rf_we = 1'b0;
        check("t2_count", count_0, 3);
        check("t2_e1_wvld", rd_wvld_0, 1);
        check("t2_e1_waddr", rd_waddr_0, 2);
        check("t2_e1_wdata", rd_wdata_0, 32'h7);
        rd_ready = 1'b1;
        tick();
        check("t2_e2_pc", rd_pc_0, 32'h10);
        check("t2_e2_wvld", rd_wvld_0, 0);
        check("t2_e2_waddr", rd_waddr_0, 0);
        check("t2_e2_wdata", rd_wdata_0, 0);
        tick();
        check("t2_e3_wvld", rd_wvld_0, 1);
        check("t2_e3_waddr", rd_waddr_0, 3);
        check("t2_e3_wdata", rd_wdata_0, 32'h33);
        tick();
        rd_ready = 1'b0;
        check("t2_drained", count_0, 0);

        // 3: full handling, 6 commits and no reads
        for (int i = 0; i < 6; i++) begin
            pc = 32'h100 + 32'(4 * i);
            tick();
        end
        check("t3_cnt0", count_0, 4);
        check("t3_cnt1", count_1, 4);
        check("t3_ovf0", overflow_0, 1);
        check("t3_ovf1", overflow_1, 1);
        check("t3_latch_clr", rd_wvld_0, 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_head0", rd_pc_0, 32'h100 + 32'(4 * i));
            check("t3_head1", rd_pc_1, 32'h108 + 32'(4 * i));
            tick();
        end
        rd_ready = 1'b0;
        check("t3_empty0", rd_valid_0, 0);
        check("t3_empty1", rd_valid_1, 0);
        check("t3_ovf_sticky", overflow_0, 1);

        // 5: full + capture + pop in the same cycle, then reset mid-drain
        trace_en = 1'b0;
        tick();
        trace_en = 1'b1;
        tick();
        check("t5_ovf_clr0", overflow_0, 0);
        check("t5_ovf_clr1", overflow_1, 0);
        for (int i = 0; i < 4; i++) begin
            pc = 32'h200 + 32'(4 * i);
            tick();
        end
        check("t5_full", count_0, 4);
        pc = 32'h210; rd_ready = 1'b1;
        tick();
        check("t5_cnt0", count_0, 4);
        check("t5_cnt1", count_1, 4);
        check("t5_ovf0", overflow_0, 0);
        check("t5_ovf1", overflow_1, 0);
        check("t5_head", rd_pc_0, 32'h204);
        tick();
        check("t5_drain", count_0, 3);
        reset = 1'b0; rd_ready = 1'b0;
        tick();
        check("t5_rst_valid", rd_valid_0, 0);
        check("t5_rst_count", count_0, 0);
        check("t5_rst_pc", rd_pc_0, 0);
        reset = 1'b1;
        tick();
        tick();
        check("t5_no_spurious", count_0, 0);

        // 4: pc trigger
        trig_en = 1'b1; trig_pc = 32'h10;
        for (int i = 1; i <= 6; i++) begin
            pc = 32'(4 * i);
            tick();
        end
        check("t4_frozen", frozen_0, 1);
        check("t4_state", dbg_state_0, FROZEN);
        check("t4_count", count_0, 4);
        check("t4_ovf", overflow_0, 0);
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t4_head", rd_pc_0, 32'(4 * i));
            tick();
        end
        rd_ready = 1'b0;
        check("t4_drained", rd_valid_0, 0);
        check("t4_still_frozen", frozen_0, 1);
        trace_en = 1'b0; trig_en = 1'b0;
        tick();
        check("t4_unfrozen", frozen_0, 0);
        check("t4_idle", dbg_state_0, IDLE);

`ifdef TRACE_TIMESTAMP_EN
        // 6: cycle stamps three cycles apart
        trace_en = 1'b1;
        tick();
        pc = 32'h40;
        tick();
        tick();
        tick();
        pc = 32'h44;
        tick();
        check("t6_count", count_0, 2);
        c0 = rd_cycle_0;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t6_delta", rd_cycle_0 - c0, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
